// File: rtl/acc_bank_pkg.sv
// Shared types for the multi-channel accumulator bank.
// Command opcodes and the result record layout.
package acc_bank_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLEAR = 2'd3
    } t_op;

    // Widest record any instance emits; instances zero-extend into it.
    localparam int RES_ACC_W = 64;
    localparam int RES_CH_W  = 8;

    typedef struct packed {
        logic [RES_CH_W-1:0]  chan;
        logic [RES_ACC_W-1:0] result;
        logic                 ovf;
        logic                 err;
    } t_result;

endpackage

// File: rtl/acc_bank_alu.sv
// Accumulator update datapath: add/sub/load/clear with wrap or saturate.
// Purely combinational; arithmetic is one bit wider than the accumulator.
module acc_bank_alu
    import acc_bank_pkg::*;
#(
    parameter int P_ACC_SIZE = 32,
    parameter int P_INC_SIZE = 16
) (
    input  logic [P_ACC_SIZE-1:0] old_val,
    input  t_op                   op,
    input  logic [P_INC_SIZE-1:0] operand,
    input  logic                  sat_mode,
    output logic [P_ACC_SIZE-1:0] new_val,
    output logic                  ovf
);

    localparam int W = P_ACC_SIZE + 1;

    logic [W-1:0] ext_old;
    logic [W-1:0] ext_opd;
    logic [W-1:0] sum;
    logic [W-1:0] diff;

    assign ext_old = {1'b0, old_val};
    assign ext_opd = {{(W - P_INC_SIZE){1'b0}}, operand};
    assign sum     = ext_old + ext_opd;
    assign diff    = ext_old - ext_opd;

    always_comb begin
        new_val = old_val;
        ovf     = 1'b0;
        unique case (op)
            OP_ADD: begin
                ovf     = sum[P_ACC_SIZE];
                new_val = (ovf && sat_mode) ? '1 : sum[P_ACC_SIZE-1:0];
            end
            OP_SUB: begin
                ovf     = diff[P_ACC_SIZE];
                new_val = (ovf && sat_mode) ? '0 : diff[P_ACC_SIZE-1:0];
            end
            OP_LOAD: begin
                new_val = ext_opd[P_ACC_SIZE-1:0];
            end
            OP_CLEAR: begin
                new_val = '0;
            end
        endcase
    end

endmodule

// File: rtl/acc_bank.sv
// Multi-channel accumulator bank with valid/ready command and result streams.
// Accumulators update at the accept edge; the result follows one cycle later.
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter  int P_ACC_SIZE = 32,
    parameter  int P_INC_SIZE = 16,
    parameter  int P_CHANNELS = 4,
    localparam int P_CH_W     = $clog2(P_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_op,
    input  logic [P_CH_W-1:0]     i_chan,
    input  logic [P_INC_SIZE-1:0] i_operand,
    input  logic                  i_sat_mode,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [P_CH_W-1:0]     o_chan,
    output logic [P_ACC_SIZE-1:0] o_result,
    output logic                  o_ovf,
    output logic                  o_err,
    input  logic [P_CH_W-1:0]     i_rd_chan,
    output logic [P_ACC_SIZE-1:0] o_rd_data,
    output logic [P_CHANNELS-1:0] o_sticky_ovf
);

    // Per-instance view of the result record at the configured widths.
    typedef struct packed {
        logic [P_CH_W-1:0]     chan;
        logic [P_ACC_SIZE-1:0] result;
        logic                  ovf;
        logic                  err;
    } t_res;

    typedef struct packed {
        logic [P_CHANNELS-1:0][P_ACC_SIZE-1:0] acc;
        logic [P_CHANNELS-1:0]                 sticky;
        t_res                                  res;
        logic                                  vld;
    } t_state;

    t_state curr;
    t_state next;

    logic                  accept;
    logic                  chan_ok;
    logic                  rd_ok;
    t_op                   op;
    logic [P_ACC_SIZE-1:0] alu_old;
    logic [P_ACC_SIZE-1:0] alu_new;
    logic                  alu_ovf;

    assign op      = t_op'(i_op);
    assign o_ready = !curr.vld || i_ready;
    assign accept  = i_valid && o_ready;
    assign chan_ok = 32'(i_chan) < P_CHANNELS;
    assign rd_ok   = 32'(i_rd_chan) < P_CHANNELS;
    assign alu_old = chan_ok ? curr.acc[i_chan] : '0;

    acc_bank_alu #(
        .P_ACC_SIZE (P_ACC_SIZE),
        .P_INC_SIZE (P_INC_SIZE)
    ) u_alu (
        .old_val  (alu_old),
        .op       (op),
        .operand  (i_operand),
        .sat_mode (i_sat_mode),
        .new_val  (alu_new),
        .ovf      (alu_ovf)
    );

    always_comb begin
        next = curr;
        if (accept) begin
            next.vld      = 1'b1;
            next.res.chan = i_chan;
            if (chan_ok) begin
                next.acc[i_chan] = alu_new;
                next.res.result  = alu_new;
                next.res.ovf     = alu_ovf;
                next.res.err     = 1'b0;
                if (op == OP_LOAD || op == OP_CLEAR) begin
                    next.sticky[i_chan] = 1'b0;
                end else if (alu_ovf) begin
                    next.sticky[i_chan] = 1'b1;
                end
            end else begin
                next.res.result = '0;
                next.res.ovf    = 1'b0;
                next.res.err    = 1'b1;
            end
        end else if (curr.vld && i_ready) begin
            next.vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            curr <= '0;
        end else begin
            curr <= next;
        end
    end

    assign o_valid      = curr.vld;
    assign o_chan       = curr.res.chan;
    assign o_result     = curr.res.result;
    assign o_ovf        = curr.res.ovf;
    assign o_err        = curr.res.err;
    assign o_sticky_ovf = curr.sticky;
    assign o_rd_data    = rd_ok ? curr.acc[i_rd_chan] : '0;

endmodule

// File: tb/tb_acc_bank.sv
// Directed vector bench for acc_bank (8-bit accumulators, 3 channels).
// Table of back-to-back commands plus backpressure and reset sequences.
module tb_acc_bank;
    import acc_bank_pkg::*;

    logic       clk;
    logic       n_rst;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] i_op;
    logic [1:0] i_chan;
    logic [7:0] i_operand;
    logic       i_sat_mode;
    logic       o_valid;
    logic       i_ready;
    logic [1:0] o_chan;
    logic [7:0] o_result;
    logic       o_ovf;
    logic       o_err;
    logic [1:0] i_rd_chan;
    logic [7:0] o_rd_data;
    logic [2:0] o_sticky_ovf;

    int total;
    int bad;

    acc_bank #(
        .P_ACC_SIZE (8),
        .P_INC_SIZE (8),
        .P_CHANNELS (3)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op         (i_op),
        .i_chan       (i_chan),
        .i_operand    (i_operand),
        .i_sat_mode   (i_sat_mode),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_chan       (o_chan),
        .o_result     (o_result),
        .o_ovf        (o_ovf),
        .o_err        (o_err),
        .i_rd_chan    (i_rd_chan),
        .o_rd_data    (o_rd_data),
        .o_sticky_ovf (o_sticky_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        t_op        op;
        logic [1:0] chan;
        logic [7:0] operand;
        logic       sat;
        logic [7:0] res;
        logic       ovf;
        logic       err;
        logic [2:0] sticky;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input t_op op, input logic [1:0] ch,
                         input logic [7:0] opd, input logic sat);
        i_valid    = 1'b1;
        i_op       = op;
        i_chan     = ch;
        i_operand  = opd;
        i_sat_mode = sat;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [7:0] exp,
                      input string name);
        i_rd_chan = ch;
        #1;
        chk(name, 32'(o_rd_data), 32'(exp));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        n_rst      = 1'b0;
        i_valid    = 1'b0;
        i_op       = 2'd0;
        i_chan     = 2'd0;
        i_operand  = 8'd0;
        i_sat_mode = 1'b0;
        i_ready    = 1'b1;
        i_rd_chan  = 2'd0;

        v[0]  = '{OP_ADD,   2'd0, 8'd5,   1'b0, 8'd5,   1'b0, 1'b0, 3'b000};
        v[1]  = '{OP_ADD,   2'd0, 8'd5,   1'b0, 8'd10,  1'b0, 1'b0, 3'b000};
        v[2]  = '{OP_ADD,   2'd0, 8'd5,   1'b0, 8'd15,  1'b0, 1'b0, 3'b000};
        v[3]  = '{OP_LOAD,  2'd1, 8'd250, 1'b0, 8'd250, 1'b0, 1'b0, 3'b000};
        v[4]  = '{OP_ADD,   2'd1, 8'd10,  1'b0, 8'd4,   1'b1, 1'b0, 3'b010};
        v[5]  = '{OP_SUB,   2'd1, 8'd5,   1'b0, 8'd255, 1'b1, 1'b0, 3'b010};
        v[6]  = '{OP_LOAD,  2'd2, 8'd250, 1'b1, 8'd250, 1'b0, 1'b0, 3'b010};
        v[7]  = '{OP_ADD,   2'd2, 8'd10,  1'b1, 8'd255, 1'b1, 1'b0, 3'b110};
        v[8]  = '{OP_SUB,   2'd2, 8'd255, 1'b1, 8'd0,   1'b0, 1'b0, 3'b110};
        v[9]  = '{OP_SUB,   2'd2, 8'd255, 1'b1, 8'd0,   1'b1, 1'b0, 3'b110};
        v[10] = '{OP_CLEAR, 2'd1, 8'd77,  1'b0, 8'd0,   1'b0, 1'b0, 3'b100};
        v[11] = '{OP_ADD,   2'd3, 8'd7,   1'b0, 8'd0,   1'b0, 1'b1, 3'b100};
        v[12] = '{OP_ADD,   2'd0, 8'd1,   1'b0, 8'd16,  1'b0, 1'b0, 3'b100};
        v[13] = '{OP_ADD,   2'd0, 8'd250, 1'b1, 8'd255, 1'b1, 1'b0, 3'b101};
        v[14] = '{OP_ADD,   2'd0, 8'd0,   1'b0, 8'd255, 1'b0, 1'b0, 3'b101};

        // Reset state
        #12;
        chk("rst_ready",  32'(o_ready),      32'd1);
        chk("rst_valid",  32'(o_valid),      32'd0);
        chk("rst_result", 32'(o_result),     32'd0);
        chk("rst_chan",   32'(o_chan),       32'd0);
        chk("rst_ovf",    32'(o_ovf),        32'd0);
        chk("rst_err",    32'(o_err),        32'd0);
        chk("rst_sticky", 32'(o_sticky_ovf), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // Back-to-back command table
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].chan, v[i].operand, v[i].sat);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'd1);
            chk($sformatf("v%0d_chan", i), 32'(o_chan), 32'(v[i].chan));
            chk($sformatf("v%0d_res", i), 32'(o_result), 32'(v[i].res));
            chk($sformatf("v%0d_ovf", i), 32'(o_ovf), 32'(v[i].ovf));
            chk($sformatf("v%0d_err", i), 32'(o_err), 32'(v[i].err));
            chk($sformatf("v%0d_sticky", i), 32'(o_sticky_ovf),
                32'(v[i].sticky));
            if (i == 2) begin
                rd(2'd0, 8'd15, "rd_ch0_15");
                rd(2'd1, 8'd0,  "rd_ch1_0");
                rd(2'd2, 8'd0,  "rd_ch2_0");
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        rd(2'd0, 8'd255, "rd_ch0_end");
        rd(2'd1, 8'd0,   "rd_ch1_end");
        rd(2'd2, 8'd0,   "rd_ch2_end");
        rd(2'd3, 8'd0,   "rd_ch3_oob");

        // Backpressure: result held for 3 cycles, then release
        @(negedge clk);
        i_ready = 1'b0;
        drive(OP_ADD, 2'd2, 8'd3, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_first", 32'(o_result), 32'd3);
        drive(OP_ADD, 2'd2, 8'd4, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_ready", c), 32'(o_ready), 32'd0);
            chk($sformatf("bp%0d_valid", c), 32'(o_valid), 32'd1);
            chk($sformatf("bp%0d_res", c), 32'(o_result), 32'd3);
            chk($sformatf("bp%0d_chan", c), 32'(o_chan), 32'd2);
            rd(2'd2, 8'd3, $sformatf("bp%0d_rd", c));
        end
        @(negedge clk);
        i_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_rel_res", 32'(o_result), 32'd7);
        chk("bp_rel_valid", 32'(o_valid), 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(o_valid), 32'd0);

        // Reset while a result is pending
        @(negedge clk);
        drive(OP_ADD, 2'd1, 8'd9, 1'b0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(o_valid),      32'd0);
        chk("mid_rst_result", 32'(o_result),     32'd0);
        chk("mid_rst_sticky", 32'(o_sticky_ovf), 32'd0);
        chk("mid_rst_ready",  32'(o_ready),      32'd1);
        rd(2'd0, 8'd0, "mid_rst_rd0");
        rd(2'd2, 8'd0, "mid_rst_rd2");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        drive(OP_ADD, 2'd0, 8'd2, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_res", 32'(o_result), 32'd2);
        chk("post_rst_ovf", 32'(o_ovf),    32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_bank.md
# acc_bank

Multi-channel accumulator bank: the parametrised successor of our single-register accumulator template. It holds P_CHANNELS independent unsigned accumulators updated by a valid/ready command stream (add, subtract, load, clear). Each channel runs in a runtime-selectable wrap or saturate mode, with per-command and sticky overflow reporting. It is the generic counter/cell store for interpreter datapath use, e.g. tape cells or loop counters.

## Interface
- P_ACC_SIZE, 32, accumulator width in bits; must be ≥ P_INC_SIZE
- P_INC_SIZE, 16, operand width in bits
- P_CHANNELS, 4, number of accumulators; must be ≥ 2
- P_CH_W, $clog2(P_CHANNELS), channel index width (derived, not overridden)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  command valid
- o_ready  out  1  command ready
- i_op  in  2  0=ADD, 1=SUB, 2=LOAD, 3=CLEAR
- i_chan  in  P_CH_W  target channel
- i_operand  in  P_INC_SIZE  unsigned operand
- i_sat_mode  in  1  0=wrap, 1=saturate; sampled with the command
- o_valid  out  1  result valid
- i_ready  in  1  result consumer ready
- o_chan  out  P_CH_W  channel of the result
- o_result  out  P_ACC_SIZE  post-update channel value
- o_ovf  out  1  this command overflowed (ADD) or underflowed (SUB)
- o_err  out  1  i_chan ≥ P_CHANNELS
- i_rd_chan  in  P_CH_W  read-port channel
- o_rd_data  out  P_ACC_SIZE  current value of i_rd_chan (combinational)
- o_sticky_ovf  out  P_CHANNELS  per-channel sticky overflow flags

## Operation
- A command is accepted when i_valid && o_ready. All inputs are sampled at that edge.
- The accumulator is written at the accept edge. The result register loads on the same edge.
- Arithmetic is done at P_ACC_SIZE+1 bits, with the operand zero-extended.
  - ADD: the carry-out is the overflow.
  - SUB: a borrow is the underflow.
- Wrap mode: the value is taken modulo 2^P_ACC_SIZE and o_ovf reflects carry/borrow.
- Saturate mode: overflow clamps to all-ones and underflow clamps to 0. o_ovf is still asserted.
- LOAD stores the zero-extended operand. CLEAR stores 0. Both force o_ovf=0 and clear that channel's sticky bit.
- Sticky bit: set by any ADD/SUB with o_ovf=1 on that channel. It stays set until LOAD/CLEAR of that channel or reset.
- Invalid channel (i_chan ≥ P_CHANNELS, possible when P_CHANNELS is not a power of two):
  - the command is accepted with no state change;
  - the result has o_result=0, o_ovf=0, o_err=1.
- Read port: o_rd_data shows the stored value. An out-of-range i_rd_chan reads 0.

## Timing
- Reset values: all accumulators 0, o_valid=0, o_result=0, o_chan=0, o_ovf=0, o_err=0, o_sticky_ovf=0.
  - o_ready=1 during and after reset.
- Latency: the result is visible on o_valid/o_result in the cycle after accept.
- o_ready = !o_valid || i_ready. This gives one command per cycle under continuous i_ready.
- While o_valid && !i_ready, all result outputs are held stable and no command is accepted.
- Back-to-back commands to the same channel are hazard-free: each sees the previous update. There are no stalls.
- o_rd_data reflects an accepted command's update from the cycle after accept.
- i_sat_mode affects only the command accepted with it. Stored values are never re-clamped.
- Reset asserted mid-stream: the pending result is dropped and all state returns to reset values immediately.

## Structure
- Package acc_bank_pkg holds:
  - t_op enum (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR);
  - t_result packed struct {chan, result, ovf, err}.
- State follows the curr/next struct pattern: accumulator array, sticky vector, result register and its valid bit.
- Sub-module acc_bank_alu: combinational; takes (old value, op, operand, sat_mode) and returns (new value, ovf). Instantiated once.

## Test plan
- Reset, then ADD 5 on ch0 three times → o_result 5, 10, 15 on consecutive cycles; o_rd_data(ch0)=15; other channels 0.
- Wrap: P_ACC_SIZE=8, LOAD 250 on ch1, then ADD 10 with wrap → o_result=4, o_ovf=1, o_sticky_ovf[1]=1. A following SUB 5 → 255, o_ovf=1.
- Saturate: P_ACC_SIZE=8, LOAD 250 on ch2, then ADD 10 with sat → 255, o_ovf=1. SUB 300 is illegal (exceeds P_INC_SIZE 8), so use SUB 255 twice → 0 then 0, second o_ovf=1.
- Backpressure: hold i_ready=0 for 3 cycles after a command → o_ready=0, outputs stable. Release → next command is accepted the same cycle.
- CLEAR on ch1 → o_result=0 and o_sticky_ovf[1] cleared. P_CHANNELS=3, i_chan=3 → o_err=1 with no state change.
- Assert n_rst while o_valid=1 → o_valid=0 and all accumulators 0 immediately. The first command after reset sees 0.
